// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared state encoding and stream framing words for the S-curve sweep
package sweep_pkg;

   // Sweep sequencer states, in the order a normal point is processed
   typedef enum logic [3:0] {
      IDLE,
      HEADER,
      LOAD,
      WAIT_CFG,
      SETTLE,
      COUNT,
      WR_DAC,
      WR_HI,
      WR_LO,
      NEXT,
      TRAILER,
      DONE
   } sweep_state_t;

   // Framing words that bracket one complete sweep in the USB stream
   localparam logic [15:0] HEADER_WORD  = 16'h5C5C;
   localparam logic [15:0] TRAILER_WORD = 16'hC5C5;

   // States that own the FIFO write port and present one word on parallel_data
   function automatic logic is_write_state(input sweep_state_t s);
      return (s == HEADER) || (s == WR_DAC) || (s == WR_HI) ||
             (s == WR_LO)  || (s == TRAILER);
   endfunction

endpackage

// File: rtl/trig_edge_counter.sv
// rtl/trig_edge_counter.sv - rising-edge trigger counter with clear, enable and saturation
module trig_edge_counter
   import sweep_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_trig,
   input  logic             i_clr,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_count
);

   logic             r_trig_d;
   logic [CNT_W-1:0] r_count;
   logic             w_edge;
   logic             w_sat;

   assign w_edge  = i_trig & ~r_trig_d;
   assign w_sat   = &r_count;
   assign o_count = r_count;

   // Previous-cycle trigger level, tracked continuously so the first window cycle has a valid history
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_trig_d <= 1'b0;
      end else begin
         r_trig_d <= i_trig;
      end
   end

   // Saturating count of 0->1 transitions while enabled; clear takes priority over counting
   always_ff @(posedge i_clk) begin
      if (i_reset || i_clr) begin
         r_count <= '0;
      end else if (i_en && w_edge && !w_sat) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/scurve_sweep_ctrl.sv
// rtl/scurve_sweep_ctrl.sv - threshold S-curve sweep sequencer streaming per-point trigger counts
module scurve_sweep_ctrl
   import sweep_pkg::*;
#(
   parameter int DAC_W         = 10,
   parameter int CNT_W         = 32,
   parameter int SETTLE_CYCLES = 400,
   parameter int CFG_TIMEOUT   = 65535
) (
   input  logic             Clk,
   input  logic             reset,
   input  logic             SweepStart,
   input  logic             SweepStop,
   input  logic [DAC_W-1:0] StartDac,
   input  logic [DAC_W-1:0] EndDac,
   input  logic [DAC_W-1:0] DacStep,
   input  logic [15:0]      CountWindow,
   input  logic             TrigIn,
   input  logic             Config_Done,
   output logic             StartLoad,
   output logic [DAC_W-1:0] DacCode,
   input  logic             ext_fifo_full,
   output logic [15:0]      parallel_data,
   output logic             parallel_data_en,
   output logic             SweepBusy,
   output logic             SweepDone,
   output logic             CfgError
);

   // One timer serves the config timeout, the settle delay and the counting window
   localparam int TMR_MAX0 = (SETTLE_CYCLES > CFG_TIMEOUT) ? SETTLE_CYCLES : CFG_TIMEOUT;
   localparam int TMR_MAX  = (TMR_MAX0 > 65535) ? TMR_MAX0 : 65535;
   localparam int TMR_W    = $clog2(TMR_MAX + 1);

   sweep_state_t     r_state;
   logic [DAC_W-1:0] r_dac;
   logic [DAC_W-1:0] r_end;
   logic [DAC_W-1:0] r_step;
   logic [15:0]      r_win;
   logic [TMR_W-1:0] r_timer;
   logic             r_cfg_d;
   logic             r_stop_pend;
   logic             r_start_load;
   logic             r_done;
   logic             r_cfg_err;
   logic [15:0]      r_data;

   logic [TMR_W-1:0] w_timer_nxt;
   logic [DAC_W:0]   w_sum;
   logic [CNT_W-1:0] w_count;
   logic [31:0]      w_count32;
   logic [15:0]      w_dac_word;
   logic             w_cfg_rise;
   logic             w_wr_state;
   logic             w_wr_go;
   logic             w_cnt_clr;
   logic             w_cnt_en;

   assign w_timer_nxt = r_timer + TMR_W'(1);
   // Extra carry bit so a step past the top of the DAC range is seen as "beyond EndDac", never a wrap
   assign w_sum       = {1'b0, r_dac} + {1'b0, r_step};
   assign w_count32   = 32'(w_count);
   assign w_dac_word  = 16'(r_dac);
   assign w_cfg_rise  = Config_Done & ~r_cfg_d;

   // A write completes in the same cycle the FIFO reports space; data is preloaded on state entry
   assign w_wr_state  = is_write_state(r_state);
   assign w_wr_go     = w_wr_state & ~ext_fifo_full;

   // Counter is held clear for the whole settle period and runs only inside the window
   assign w_cnt_clr   = (r_state == SETTLE);
   assign w_cnt_en    = (r_state == COUNT);

   assign StartLoad        = r_start_load;
   assign DacCode          = r_dac;
   assign parallel_data    = r_data;
   assign parallel_data_en = w_wr_go;
   assign SweepBusy        = (r_state != IDLE);
   assign SweepDone        = r_done;
   assign CfgError         = r_cfg_err;

   trig_edge_counter #(
      .CNT_W   (CNT_W)
   ) u_trig_cnt (
      .i_clk   (Clk),
      .i_reset (reset),
      .i_trig  (TrigIn),
      .i_clr   (w_cnt_clr),
      .i_en    (w_cnt_en),
      .o_count (w_count)
   );

   // Sweep sequencer: per point load config, settle, count, then emit DAC code and 32-bit count
   always_ff @(posedge Clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_dac        <= '0;
         r_end        <= '0;
         r_step       <= '0;
         r_win        <= '0;
         r_timer      <= '0;
         r_cfg_d      <= 1'b0;
         r_stop_pend  <= 1'b0;
         r_start_load <= 1'b0;
         r_done       <= 1'b0;
         r_cfg_err    <= 1'b0;
         r_data       <= '0;
      end else begin
         r_start_load <= 1'b0;
         r_done       <= 1'b0;
         r_cfg_d      <= Config_Done;

         unique case (r_state)
            IDLE: begin
               if (SweepStart) begin
                  r_dac       <= StartDac;
                  r_end       <= EndDac;
                  r_step      <= (DacStep == '0) ? DAC_W'(1) : DacStep;
                  r_win       <= (CountWindow == '0) ? 16'd1 : CountWindow;
                  r_cfg_err   <= 1'b0;
                  r_stop_pend <= 1'b0;
                  r_data      <= HEADER_WORD;
                  r_state     <= HEADER;
               end
            end

            HEADER: begin
               if (!ext_fifo_full) begin
                  if (r_dac > r_end) begin
                     r_data  <= TRAILER_WORD;
                     r_state <= TRAILER;
                  end else begin
                     r_state <= LOAD;
                  end
               end
            end

            LOAD: begin
               if (SweepStop) begin
                  r_data  <= TRAILER_WORD;
                  r_state <= TRAILER;
               end else begin
                  r_start_load <= 1'b1;
                  r_timer      <= '0;
                  r_state      <= WAIT_CFG;
               end
            end

            WAIT_CFG: begin
               if (SweepStop) begin
                  r_data  <= TRAILER_WORD;
                  r_state <= TRAILER;
               end else if (w_cfg_rise) begin
                  r_timer <= '0;
                  r_state <= SETTLE;
               end else if (w_timer_nxt == TMR_W'(CFG_TIMEOUT)) begin
                  r_cfg_err <= 1'b1;
                  r_data    <= TRAILER_WORD;
                  r_state   <= TRAILER;
               end else begin
                  r_timer <= w_timer_nxt;
               end
            end

            SETTLE: begin
               if (SweepStop) begin
                  r_data  <= TRAILER_WORD;
                  r_state <= TRAILER;
               end else if (w_timer_nxt == TMR_W'(SETTLE_CYCLES)) begin
                  r_timer <= '0;
                  r_state <= COUNT;
               end else begin
                  r_timer <= w_timer_nxt;
               end
            end

            COUNT: begin
               if (SweepStop) begin
                  r_data  <= TRAILER_WORD;
                  r_state <= TRAILER;
               end else if (w_timer_nxt == TMR_W'(r_win)) begin
                  r_data  <= w_dac_word;
                  r_state <= WR_DAC;
               end else begin
                  r_timer <= w_timer_nxt;
               end
            end

            WR_DAC: begin
               if (SweepStop) r_stop_pend <= 1'b1;
               if (!ext_fifo_full) begin
                  r_data  <= w_count32[31:16];
                  r_state <= WR_HI;
               end
            end

            WR_HI: begin
               if (SweepStop) r_stop_pend <= 1'b1;
               if (!ext_fifo_full) begin
                  r_data  <= w_count32[15:0];
                  r_state <= WR_LO;
               end
            end

            WR_LO: begin
               if (SweepStop) r_stop_pend <= 1'b1;
               if (!ext_fifo_full) begin
                  if (SweepStop || r_stop_pend) begin
                     r_data  <= TRAILER_WORD;
                     r_state <= TRAILER;
                  end else begin
                     r_state <= NEXT;
                  end
               end
            end

            NEXT: begin
               if (SweepStop || (w_sum > {1'b0, r_end})) begin
                  r_data  <= TRAILER_WORD;
                  r_state <= TRAILER;
               end else begin
                  r_dac   <= w_sum[DAC_W-1:0];
                  r_state <= LOAD;
               end
            end

            TRAILER: begin
               if (!ext_fifo_full) begin
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end

            DONE: begin
               r_state <= IDLE;
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_scurve_sweep_ctrl.sv
// tb/tb_scurve_sweep_ctrl.sv - randomized self-checking bench for scurve_sweep_ctrl
`timescale 1ns/1ps
module tb_scurve_sweep_ctrl;

   localparam int SETTLE = 400;
   localparam int CFG_TO = 65535;
   localparam int MAXCYC = 120000;

   logic        Clk = 1'b0;
   logic        reset;
   logic        SweepStart;
   logic        SweepStop;
   logic [9:0]  StartDac;
   logic [9:0]  EndDac;
   logic [9:0]  DacStep;
   logic [15:0] CountWindow;
   logic        TrigIn;
   logic        Config_Done;
   logic        ext_fifo_full;
   logic        StartLoad;
   logic [9:0]  DacCode;
   logic [15:0] parallel_data;
   logic        parallel_data_en;
   logic        SweepBusy;
   logic        SweepDone;
   logic        CfgError;

   always #12.5 Clk = ~Clk;

   scurve_sweep_ctrl #(
      .DAC_W            (10),
      .CNT_W            (32),
      .SETTLE_CYCLES    (SETTLE),
      .CFG_TIMEOUT      (CFG_TO)
   ) dut (
      .Clk              (Clk),
      .reset            (reset),
      .SweepStart       (SweepStart),
      .SweepStop        (SweepStop),
      .StartDac         (StartDac),
      .EndDac           (EndDac),
      .DacStep          (DacStep),
      .CountWindow      (CountWindow),
      .TrigIn           (TrigIn),
      .Config_Done      (Config_Done),
      .StartLoad        (StartLoad),
      .DacCode          (DacCode),
      .ext_fifo_full    (ext_fifo_full),
      .parallel_data    (parallel_data),
      .parallel_data_en (parallel_data_en),
      .SweepBusy        (SweepBusy),
      .SweepDone        (SweepDone),
      .CfgError         (CfgError)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // stimulus modes read by the driver processes
   int trig_mode = 0;   // 0 low, 1 toggle every 10 cycles, 2 random
   int full_mode = 0;   // 0 never full, 1 random, 2 forced full
   int cfg_ack   = 1;   // 1 acknowledge each StartLoad with a Config_Done rising edge

   initial begin
      int tcnt;
      tcnt = 0;
      TrigIn = 1'b0;
      forever begin
         @(posedge Clk); #1;
         case (trig_mode)
            1: begin
               if (tcnt == 9) begin TrigIn = ~TrigIn; tcnt = 0; end
               else tcnt++;
            end
            2: if ($urandom_range(0, 3) == 0) TrigIn = ~TrigIn;
            default: TrigIn = 1'b0;
         endcase
      end
   end

   initial begin
      ext_fifo_full = 1'b0;
      forever begin
         @(posedge Clk); #1;
         case (full_mode)
            1: ext_fifo_full = ($urandom_range(0, 3) == 0);
            2: ext_fifo_full = 1'b1;
            default: ext_fifo_full = 1'b0;
         endcase
      end
   end

   initial begin
      int d;
      Config_Done = 1'b0;
      forever begin
         @(posedge Clk); #1;
         if (cfg_ack == 0) begin
            Config_Done = 1'b0;
         end else if (StartLoad) begin
            Config_Done = 1'b0;
            d = $urandom_range(2, 12);
            repeat (d) @(posedge Clk);
            #1;
            Config_Done = 1'b1;
         end
      end
   end

   // observation history, indexed by the cycle whose posedge follows each negedge
   bit          trig_h [MAXCYC];
   bit          cd_h   [MAXCYC];
   int          cyc     = 0;
   logic [15:0] wq[$];
   int          rises[$];
   int          sl_cnt  = 0;
   int          done_cnt = 0;
   int          full_wr = 0;
   int          dac_max = 0;

   always @(negedge Clk) begin
      if (cyc < MAXCYC - 1) cyc++;
      trig_h[cyc] = TrigIn;
      cd_h[cyc]   = Config_Done;
      if (SweepStart) dac_max = 0;
      if (reset === 1'b0) begin
         if (Config_Done && !cd_h[cyc-1]) rises.push_back(cyc);
         if (parallel_data_en === 1'b1) begin
            wq.push_back(parallel_data);
            if (ext_fifo_full) full_wr++;
         end
         if (StartLoad === 1'b1) sl_cnt++;
         if (SweepDone === 1'b1) done_cnt++;
         if (SweepBusy === 1'b1 && int'(DacCode) > dac_max) dac_max = int'(DacCode);
      end
   end

   int w0, r0, sl0, d0, f0;
   logic [15:0] exp_q[$];

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge Clk); #1;
      end
   endtask

   task automatic snap();
      w0 = wq.size(); r0 = rises.size(); sl0 = sl_cnt; d0 = done_cnt; f0 = full_wr;
   endtask

   task automatic start_sweep(input int s, input int e, input int st, input int w);
      snap();
      StartDac    = s[9:0];
      EndDac      = e[9:0];
      DacStep     = st[9:0];
      CountWindow = w[15:0];
      SweepStart  = 1'b1;
      tick(1);
      SweepStart  = 1'b0;
   endtask

   // number of trigger rising edges in the window that follows a Config_Done rise at cycle r
   function automatic int count_edges(input int r, input int we);
      int c;
      c = 0;
      for (int k = r + SETTLE + 1; k <= r + SETTLE + we; k++)
         if (k < MAXCYC && trig_h[k] && !trig_h[k-1]) c++;
      return c;
   endfunction

   task automatic build_exp(input int s, input int e, input int st, input int w,
                            input int max_pts, output int npts);
      int ste, we, d, c;
      ste = (st == 0) ? 1 : st;
      we  = (w == 0) ? 1 : w;
      exp_q.delete();
      exp_q.push_back(16'h5C5C);
      npts = 0;
      d = s;
      while (d <= e && npts < max_pts) begin
         if (r0 + npts < rises.size()) c = count_edges(rises[r0 + npts], we);
         else c = -1;
         exp_q.push_back(d[15:0]);
         exp_q.push_back(c[31:16]);
         exp_q.push_back(c[15:0]);
         npts++;
         d += ste;
      end
      exp_q.push_back(16'hC5C5);
   endtask

   task automatic finish_sweep(input string tag, input int s, input int e, input int st,
                               input int w, input int max_pts, input int exp_sl_in,
                               input int exp_err, input int budget);
      int n, npts, exp_sl, ste;
      n = 0;
      while (done_cnt == d0 && n < budget) begin tick(1); n++; end
      tick(3);
      check_eq({tag, "_done"}, done_cnt - d0, 1);
      build_exp(s, e, st, w, max_pts, npts);
      check_eq({tag, "_nwords"}, wq.size() - w0, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (w0 + i < wq.size())
            check_eq($sformatf("%s_w%0d", tag, i), wq[w0 + i], exp_q[i]);
      exp_sl = (exp_sl_in < 0) ? npts : exp_sl_in;
      ste = (st == 0) ? 1 : st;
      check_eq({tag, "_startload"}, sl_cnt - sl0, exp_sl);
      check_eq({tag, "_dacmax"}, dac_max, (exp_sl > 0) ? s + ste * (exp_sl - 1) : s);
      check_eq({tag, "_cfgerr"}, CfgError, exp_err);
      check_eq({tag, "_busy_idle"}, SweepBusy, 0);
      check_eq({tag, "_wr_while_full"}, full_wr - f0, 0);
   endtask

   initial begin
      int s, e, st, w, ste, n, en_seen, chg;
      logic [15:0] d_ref;
      reset = 1'b1; SweepStart = 1'b0; SweepStop = 1'b0;
      StartDac = '0; EndDac = '0; DacStep = '0; CountWindow = '0;
      tick(4);
      check_eq("rst_busy", SweepBusy, 0);
      check_eq("rst_startload", StartLoad, 0);
      check_eq("rst_en", parallel_data_en, 0);
      check_eq("rst_done", SweepDone, 0);
      check_eq("rst_cfgerr", CfgError, 0);
      check_eq("rst_dac", DacCode, 0);
      check_eq("rst_data", parallel_data, 0);
      reset = 1'b0;
      tick(2);

      // three-point sweep, trigger toggling every 10 cycles
      trig_mode = 1; full_mode = 0; cfg_ack = 1;
      start_sweep(100, 102, 1, 1000);
      finish_sweep("t1", 100, 102, 1, 1000, 99, -1, 0, 20000);
      if (w0 + 3 < wq.size()) check_eq("t1_pt0_lo_50", wq[w0 + 3], 16'h0032);

      // step that overshoots EndDac, random trigger and FIFO backpressure
      trig_mode = 2; full_mode = 1;
      start_sweep(10, 20, 4, 30);
      finish_sweep("t2", 10, 20, 4, 30, 99, -1, 0, 10000);

      // randomized sweeps, with zero step/window occasionally, then top-of-range boundary
      for (int k = 0; k < 3; k++) begin
         s  = $urandom_range(0, 1000);
         st = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 40);
         w  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 60);
         ste = (st == 0) ? 1 : st;
         e  = s + ste * $urandom_range(0, 3) + $urandom_range(0, ste - 1);
         if (e > 1023) e = 1023;
         start_sweep(s, e, st, w);
         finish_sweep($sformatf("rnd%0d", k), s, e, st, w, 99, -1, 0, 10000);
      end
      start_sweep(1015, 1023, 8, 25);
      finish_sweep("top", 1015, 1023, 8, 25, 99, -1, 0, 10000);

      // Config_Done never rises: timeout, error flag, framing only
      full_mode = 0; trig_mode = 0; cfg_ack = 0;
      start_sweep(0, 0, 1, 10);
      finish_sweep("tmo", 0, 0, 1, 10, 0, 1, 1, CFG_TO + 2000);
      tick(5);
      check_eq("tmo_cfgerr_sticky", CfgError, 1);

      // StartDac above EndDac: header and trailer only, error cleared by the new start
      cfg_ack = 1;
      start_sweep(5, 3, 1, 10);
      check_eq("empty_cfgerr_cleared", CfgError, 0);
      finish_sweep("empty", 5, 3, 1, 10, 99, 0, 0, 1000);

      // stop during the counting window of the second point
      trig_mode = 2;
      start_sweep(200, 210, 1, 200);
      n = 0;
      while (rises.size() - r0 < 2 && n < 5000) begin tick(1); n++; end
      tick(SETTLE + 20);
      SweepStop = 1'b1;
      tick(1);
      SweepStop = 1'b0;
      finish_sweep("stop", 200, 210, 1, 200, 1, 2, 0, 2000);

      // FIFO full for 50 cycles while the count high word is pending
      start_sweep(7, 7, 1, 20);
      n = 0;
      while (wq.size() - w0 < 2 && n < 3000) begin @(negedge Clk); #1; n++; end
      full_mode = 2;
      en_seen = 0; chg = 0;
      @(negedge Clk); #1;
      d_ref = parallel_data;
      for (int i = 0; i < 50; i++) begin
         @(negedge Clk); #1;
         if (parallel_data_en) en_seen++;
         if (parallel_data !== d_ref) chg++;
      end
      check_eq("full_no_en", en_seen, 0);
      check_eq("full_data_stable", chg, 0);
      check_eq("full_words_held", wq.size() - w0, 2);
      full_mode = 0;
      finish_sweep("full", 7, 7, 1, 20, 99, -1, 0, 2000);

      // reset in the middle of a counting window: no trailer, no done
      start_sweep(1, 3, 1, 50);
      n = 0;
      while (rises.size() - r0 < 1 && n < 3000) begin tick(1); n++; end
      tick(SETTLE + 10);
      reset = 1'b1;
      tick(2);
      check_eq("mid_rst_busy", SweepBusy, 0);
      check_eq("mid_rst_dac", DacCode, 0);
      check_eq("mid_rst_en", parallel_data_en, 0);
      check_eq("mid_rst_data", parallel_data, 0);
      reset = 1'b0;
      tick(40);
      check_eq("mid_rst_words", wq.size() - w0, 1);
      check_eq("mid_rst_no_done", done_cnt - d0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/scurve_sweep_ctrl.md
SCURVE_SWEEP_CTRL -- requirements
Module: scurve_sweep_ctrl

Interface
REQ-001 Parameter DAC_W, 10, width of the threshold DAC code.
REQ-002 Parameter CNT_W, 32, trigger counter width.
REQ-003 Parameter SETTLE_CYCLES, 400, Clk cycles waited after Config_Done before counting (10 us at 40 MHz).
REQ-004 Parameter CFG_TIMEOUT, 65535, maximum Clk cycles to wait for Config_Done.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high: Clk in 1, the 40 MHz system clock; reset in 1, synchronous active-high reset.
REQ-006 SweepStart in 1: single-cycle start pulse; ignored unless IDLE.
REQ-007 SweepStop in 1: abort request, level or pulse.
REQ-008 StartDac in DAC_W, EndDac in DAC_W, DacStep in DAC_W: sweep range and increment.
REQ-009 CountWindow in 16: counting window in Clk cycles.
REQ-010 TrigIn in 1: Clk-synchronous trigger level (OR of ASIC discriminators).
REQ-011 Config_Done in 1: slow-control load complete, level.
REQ-012 StartLoad out 1: single-cycle pulse that requests a slow-control reload.
REQ-013 DacCode out DAC_W: threshold presented to the slow-control register image.
REQ-014 ext_fifo_full in 1; parallel_data out 16; parallel_data_en out 1: write port to the USB FIFO.
REQ-015 SweepBusy out 1; SweepDone out 1 (single-cycle pulse); CfgError out 1 (sticky until the next SweepStart).

Function
REQ-016 At SweepStart the block SHALL latch StartDac, EndDac, DacStep and CountWindow. DacStep=0 SHALL be treated as 1. CountWindow=0 SHALL be treated as 1.
REQ-017 States SHALL be IDLE, HEADER, LOAD, WAIT_CFG, SETTLE, COUNT, WR_DAC, WR_HI, WR_LO, NEXT, TRAILER and DONE.
REQ-018 IDLE->HEADER on SweepStart, with DacCode<=StartDac. HEADER writes 16'h5C5C. If StartDac>EndDac, HEADER SHALL go directly to TRAILER; otherwise it goes to LOAD.
REQ-019 LOAD SHALL pulse StartLoad for exactly one cycle, then go to WAIT_CFG.
REQ-020 WAIT_CFG SHALL wait for a Config_Done rising edge, then go to SETTLE. After CFG_TIMEOUT cycles with no edge it SHALL set CfgError and go to TRAILER.
REQ-021 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to COUNT with the counter cleared.
REQ-022 COUNT SHALL last exactly CountWindow cycles and increment on each TrigIn 0->1 edge (previous-cycle register), including an edge in the final window cycle.
REQ-023 The counter SHALL saturate at all-ones.
REQ-024 Write states SHALL emit, in order, {6'b0,DacCode}, count[31:16] and count[15:0].
REQ-025 Each word SHALL be written with parallel_data_en high for exactly one cycle, only when ext_fifo_full=0. While ext_fifo_full=1 the block holds its state with the data stable.
REQ-026 NEXT: if DacCode+DacStep (DAC_W+1-bit sum) > EndDac, go to TRAILER; otherwise set DacCode<=DacCode+DacStep and go to LOAD. DacCode SHALL never exceed EndDac or wrap.
REQ-027 TRAILER SHALL write 16'hC5C5, then go to DONE. DONE SHALL pulse SweepDone for one cycle and return to IDLE.
REQ-028 SweepStop in LOAD, WAIT_CFG, SETTLE or COUNT SHALL go to TRAILER on the next cycle with no partial point written.
REQ-029 SweepStop in WR_DAC, WR_HI or WR_LO SHALL let the current point complete before going to TRAILER.
REQ-030 SweepStop in IDLE SHALL be ignored.
REQ-031 SweepBusy SHALL be high in every state except IDLE.

Reset
REQ-032 On reset: state IDLE; StartLoad, parallel_data_en, SweepDone and CfgError low; SweepBusy low; DacCode=0; parallel_data=0; counter and timers cleared.
REQ-033 Reset mid-sweep SHALL abort without emitting a trailer.

Structure
REQ-034 A shared package sweep_pkg SHALL hold the state enumeration and the constants HEADER_WORD=16'h5C5C and TRAILER_WORD=16'hC5C5.
REQ-035 One sub-module, trig_edge_counter, SHALL contain the edge detect, the saturating counter and the clear/enable inputs.

Verification
REQ-036 StartDac=100, EndDac=102, DacStep=1, CountWindow=1000, TrigIn toggling every 10 cycles, Config_Done acknowledged -> words 5C5C, then (0064,0000,0032), (0065,...), (0066,...), then C5C5, then SweepDone.
REQ-037 StartDac=10, EndDac=20, DacStep=4 -> points 10, 14 and 18 only; DacCode is never 22.
REQ-038 Config_Done held low -> CfgError=1 after 65535 cycles; output is 5C5C followed by C5C5.
REQ-039 ext_fifo_full=1 for 50 cycles during WR_HI -> no parallel_data_en in that time, data stable, word written once after release.
REQ-040 SweepStop during COUNT of the second point -> first point's 3 words, then C5C5, then SweepDone.
REQ-041 StartDac=5, EndDac=3 -> 5C5C followed by C5C5; StartLoad never pulses.
